// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared state encoding, default widths and response codes for the APB bridge.
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int c_ADDR_W_DEF = 5;
    localparam int c_DATA_W_DEF = 32;

    localparam logic c_RSP_OK  = 1'b0;
    localparam logic c_RSP_ERR = 1'b1;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : Valid/ready command to APB requester with timeout and error response.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter  int ADDR_W      = c_ADDR_W_DEF,
    parameter  int DATA_W      = c_DATA_W_DEF,
    parameter  int NUM_SEL     = 2,
    parameter  int TIMEOUT_CYC = 16,
    localparam int SEL_W       = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [SEL_W-1:0]  cmd_slave,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [NUM_SEL-1:0] Psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int c_CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYC);

    state_e              state_q,     state_d;
    logic [NUM_SEL-1:0]  psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic                pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;
    logic [c_CNT_W-1:0]  cnt_q,       cnt_d;
    logic                bad_q,       bad_d;

    logic                cmd_bad;
    logic [NUM_SEL-1:0]  sel_onehot;
    logic [c_CNT_W-1:0]  cnt_inc;

    assign cmd_bad = (32'(cmd_slave) >= NUM_SEL);

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (32'(cmd_slave) == i) begin
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= c_RSP_OK;
            cnt_q       <= '0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        bad_d       = bad_q;
        cnt_inc     = cnt_q + c_CNT_W'(1);

        case (state_q)
            IDLE: begin
                // APB fields load at accept so they are already valid in SETUP
                if (cmd_valid) begin
                    state_d  = SETUP;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    bad_d    = cmd_bad;
                    psel_d   = cmd_bad ? '0 : sel_onehot;
                    cnt_d    = '0;
                end
            end
            SETUP: begin
                if (bad_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = c_RSP_ERR;
                    rsp_rdata_d = '0;
                end else begin
                    state_d   = ACCESS;
                    penable_d = 1'b1;
                end
            end
            ACCESS: begin
                if (pready) begin
                    state_d     = RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = c_RSP_OK;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                end else if (TIMEOUT_CYC != 0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == c_TIMEOUT) begin
                        state_d     = RESP;
                        psel_d      = '0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = c_RSP_ERR;
                        rsp_rdata_d = '0;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = c_RSP_OK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign Psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule : apb_master_bridge
`default_nettype wire
